// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, shift start..stop on device clock falls, then check ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             fe, sdata, timeout, abort;

  assign fe      = clk_sync_q[2] & ~clk_sync_q[1];
  assign sdata   = data_sync_q[1];
  // A device clock fall in the expiry cycle rescues the transfer.
  assign timeout = ~fe & (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    abort       = 1'b0;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d    = {1'b1, ~^tx_data, tx_data};
          cnt_d      = '0;
          bitcnt_d   = '0;
          err_code_d = 2'b00;
          clk_oe_d   = 1'b1;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        cnt_d = fe ? '0 : cnt_q + 1'b1;
        if (fe) begin
          data_oe_d = ~frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        cnt_d = fe ? '0 : cnt_q + 1'b1;
        if (fe) begin
          if (!sdata) begin
            state_d = S_RELEASE;
          end else begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_IDLE;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d = fe ? '0 : cnt_q + 1'b1;
        if (clk_sync_q[1] && sdata) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      err_d      = 1'b1;
      err_code_d = 2'b10;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with a PS/2 device model and event-level reference
module tb_ps2_host_tx;
  localparam int INH = 16;
  localparam int TO  = 60;
  localparam int BIG = 32'h3fff_ffff;
  localparam int K_NONE = 0, K_DONE = 1, K_ERR = 2;
  localparam int M_ACK = 0, M_NOACK = 1, M_STALL = 2, M_RST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a transfer occupies the block from accept until the outcome cycle the device model predicts.
  logic       m_idle = 1'b1;
  int         acc_cyc = 0;
  logic [1:0] m_code = 2'b00;
  int         evt_cyc = BIG;
  int         evt_kind = K_NONE;
  logic [1:0] evt_code = 2'b00;
  logic [9:0] last_frame = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idle <= 1'b1;
      m_code <= 2'b00;
    end else if (m_idle) begin
      if (tx_valid) begin
        m_idle  <= 1'b0;
        acc_cyc <= cyc + 1;
        m_code  <= 2'b00;
      end
    end else if (cyc + 1 == evt_cyc) begin
      m_idle <= 1'b1;
      if (evt_kind == K_ERR) m_code <= evt_code;
    end
  end

  always @(negedge clk) begin
    int n;
    if (rst) begin
      n = cyc - acc_cyc + 1;
      chk("tx_ready", tx_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("done", done, (evt_kind == K_DONE) && (cyc == evt_cyc));
      chk("err", err, (evt_kind == K_ERR) && (cyc == evt_cyc));
      chk("err_code", err_code, m_code);
      if (m_idle) begin
        chk("idle_clk_oe", ps2_clk_oe, 0);
        chk("idle_data_oe", ps2_data_oe, 0);
      end else begin
        chk("clk_oe", ps2_clk_oe, n <= INH + 1);
        if (n <= INH + 1) chk("rts_data_oe", ps2_data_oe, n == INH + 1);
      end
    end
  end

  task automatic dev_fall(output int c);
    @(negedge clk);
    dev_clk_low = 1'b1;
    c = cyc;
  endtask

  task automatic dev_rise(input int h, output logic s);
    repeat (h) @(negedge clk);
    s = ps2_data;
    dev_clk_low = 1'b0;
    repeat (h) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int mode, input int h, input bit intrude);
    logic [9:0] want, got;
    logic s;
    int c, lowcnt;
    bit seen, fin;
    want = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
    got = '0;
    evt_cyc  = BIG;
    evt_kind = (mode == M_ACK) ? K_DONE : ((mode == M_RST) ? K_NONE : K_ERR);
    evt_code = (mode == M_NOACK) ? 2'b01 : 2'b10;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    lowcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (!ps2_clk) lowcnt++;
      else if (lowcnt > 0) seen = 1'b1;
      if (!seen) @(negedge clk);
    end
    chk("rts_seen", seen, 1);
    chk("inhibit_len", lowcnt, INH + 1);
    chk("start_bit", ps2_data, 0);
    if (intrude) begin
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      if (mode == M_RST && k == 5) break;
      dev_fall(c);
      if (mode == M_STALL && k == 3) evt_cyc = c + 3 + TO;
      dev_rise(h, s);
      got[k] = s;
      if (intrude && k == 3) tx_valid = 1'b0;
      if (mode == M_STALL && k == 3) break;
    end
    case (mode)
      M_ACK: begin
        chk("frame", got, want);
        dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_fall(c);
        dev_rise(h, s);
        dev_data_low = 1'b0;
        evt_cyc = cyc + 3;
      end
      M_NOACK: begin
        chk("frame", got, want);
        dev_fall(c);
        evt_cyc = c + 3;
        dev_rise(h, s);
      end
      M_RST: begin
        chk("pre_reset_data_oe", ps2_data_oe, !want[4]);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
      end
      default: ;
    endcase
    if (mode != M_RST) begin
      fin = 1'b0;
      for (int i = 0; i < 1000 && !fin; i++) begin
        @(negedge clk);
        fin = (cyc > evt_cyc) && m_idle;
      end
      chk("transfer_finished", fin, 1);
    end
    last_frame = got;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hED, M_ACK, 6, 1'b0);
    chk("ed_frame_literal", last_frame, 10'h3ED);
    chk("ed_ready", tx_ready, 1);

    send(8'h02, M_ACK, 5, 1'b0);
    chk("02_frame_literal", last_frame, 10'h202);

    send(8'hFF, M_NOACK, 6, 1'b0);
    chk("noack_frame_literal", last_frame, 10'h3FF);
    chk("noack_code_literal", err_code, 2'b01);

    send(8'hF3, M_STALL, 6, 1'b0);
    chk("timeout_code_literal", err_code, 2'b10);

    send(8'hED, M_ACK, 7, 1'b1);
    chk("intrude_frame_literal", last_frame, 10'h3ED);

    send(8'hED, M_RST, 6, 1'b0);
    send(8'h02, M_ACK, 6, 1'b0);
    chk("after_reset_frame", last_frame, 10'h202);

    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rb = 8'($urandom);
      send(rb, ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK, $urandom_range(4, 8), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
